// File: rtl/craps_turn_ctrl.sv
// Two-player craps turn scheduler: owns the dice roller grant, evaluates settled sums,
// keeps round scores and ends the match once a player reaches WIN_TARGET round wins.
module craps_turn_ctrl #(
    parameter int unsigned WIN_TARGET = 3,
    parameter int unsigned RESULT_CYC = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll_a,
    input  logic       roll_b,
    input  logic [3:0] sum,
    output logic       inc,
    output logic       turn_b,
    output logic [3:0] point,
    output logic       round_win,
    output logic       round_lose,
    output logic [3:0] score_a,
    output logic [3:0] score_b,
    output logic       match_over,
    output logic       winner_b
);

    typedef enum logic [2:0] {
        StComeWait,
        StComeRoll,
        StComeEval,
        StPtWait,
        StPtRoll,
        StPtEval,
        StResult,
        StMatchEnd
    } state_e;

    localparam logic [3:0]       Target  = 4'(WIN_TARGET);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(RESULT_CYC - 1);

    state_e           state_q, state_d;
    logic             turn_q, turn_d;
    logic [3:0]       point_q, point_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic [3:0]       score_a_q, score_a_d;
    logic [3:0]       score_b_q, score_b_d;
    logic             winner_q, winner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       act_roll;
    logic [3:0] act_score;
    logic       win_entry;
    logic       lose_entry;

    assign act_roll  = turn_q ? roll_b : roll_a;
    assign act_score = turn_q ? score_b_q : score_a_q;

    always_comb begin
        state_d    = state_q;
        turn_d     = turn_q;
        point_d    = point_q;
        win_d      = win_q;
        lose_d     = lose_q;
        score_a_d  = score_a_q;
        score_b_d  = score_b_q;
        winner_d   = winner_q;
        cnt_d      = cnt_q;
        inc        = 1'b0;
        win_entry  = 1'b0;
        lose_entry = 1'b0;

        unique case (state_q)
            StComeWait: if (act_roll) state_d = StComeRoll;
            StComeRoll: begin
                inc = act_roll;
                if (!act_roll) state_d = StComeEval;
            end
            StComeEval: begin
                case (sum)
                    4'd7, 4'd11:       win_entry  = 1'b1;
                    4'd2, 4'd3, 4'd12: lose_entry = 1'b1;
                    4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10: begin
                        point_d = sum;
                        state_d = StPtWait;
                    end
                    default:           state_d = StComeWait;
                endcase
            end
            StPtWait: if (act_roll) state_d = StPtRoll;
            StPtRoll: begin
                inc = act_roll;
                if (!act_roll) state_d = StPtEval;
            end
            StPtEval: begin
                if (sum == point_q)    win_entry  = 1'b1;
                else if (sum == 4'd7)  lose_entry = 1'b1;
                else                   state_d    = StPtWait;
            end
            StResult: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    point_d = '0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    if (act_score == Target) begin
                        winner_d = turn_q;
                        state_d  = StMatchEnd;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = StComeWait;
                    end
                end
            end
            StMatchEnd: state_d = StMatchEnd;
            default:    state_d = StComeWait;
        endcase

        // The score bump lands on the same edge that enters RESULT.
        if (win_entry || lose_entry) begin
            state_d = StResult;
            cnt_d   = '0;
            win_d   = win_entry;
            lose_d  = lose_entry;
            if (win_entry) begin
                if (turn_q) score_b_d = score_b_q + 4'd1;
                else        score_a_d = score_a_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StComeWait;
            turn_q    <= 1'b0;
            point_q   <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            score_a_q <= '0;
            score_b_q <= '0;
            winner_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            point_q   <= point_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            winner_q  <= winner_d;
            cnt_q     <= cnt_d;
        end
    end

    assign turn_b     = turn_q;
    assign point      = point_q;
    assign round_win  = win_q;
    assign round_lose = lose_q;
    assign score_a    = score_a_q;
    assign score_b    = score_b_q;
    assign match_over = (state_q == StMatchEnd);
    assign winner_b   = winner_q;

endmodule

// File: tb/tb_craps_turn_ctrl.sv
// Scoreboard bench for craps_turn_ctrl: a game-level model queues expected inc bursts and
// round results; a negedge monitor pops and compares whenever the DUT shows them.
module tb_craps_turn_ctrl;

    localparam int unsigned WIN_TARGET = 3;
    localparam int unsigned RESULT_CYC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       roll_a, roll_b;
    logic [3:0] sum;
    logic       inc, turn_b, round_win, round_lose, match_over, winner_b;
    logic [3:0] point, score_a, score_b;

    craps_turn_ctrl #(
        .WIN_TARGET(WIN_TARGET),
        .RESULT_CYC(RESULT_CYC),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .roll_a    (roll_a),
        .roll_b    (roll_b),
        .sum       (sum),
        .inc       (inc),
        .turn_b    (turn_b),
        .point     (point),
        .round_win (round_win),
        .round_lose(round_lose),
        .score_a   (score_a),
        .score_b   (score_b),
        .match_over(match_over),
        .winner_b  (winner_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       win;
        logic [3:0] sa;
        logic [3:0] sb;
        logic       turn;
        logic [3:0] pt;
    } res_t;

    int   inc_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Game-level reference state
    int m_turn, m_point, m_over, m_winner;
    int m_score[2];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_turn = 0; m_point = 0; m_over = 0; m_winner = 0;
        m_score[0] = 0; m_score[1] = 0;
    endtask

    // Applies craps rules to one roll of value s after a press of h cycles.
    task automatic model_roll(input int h, input int s);
        int   dec, win;
        res_t r;
        if (m_over != 0) return;
        inc_q.push_back(h - 1);
        dec = 0; win = 0;
        if (m_point == 0) begin
            if (s == 7 || s == 11)               begin dec = 1; win = 1; end
            else if (s == 2 || s == 3 || s == 12) dec = 1;
            else if (s >= 4 && s <= 10)          m_point = s;
        end else begin
            if (s == m_point)  begin dec = 1; win = 1; end
            else if (s == 7)   dec = 1;
        end
        if (dec != 0) begin
            if (win != 0) m_score[m_turn]++;
            r.win  = 1'(win);
            r.sa   = 4'(m_score[0]);
            r.sb   = 4'(m_score[1]);
            r.turn = 1'(m_turn);
            r.pt   = 4'(m_point);
            res_q.push_back(r);
            m_point = 0;
            if (m_score[m_turn] == int'(WIN_TARGET)) begin
                m_over = 1; m_winner = m_turn;
            end else begin
                m_turn ^= 1;
            end
        end
    endtask

    task automatic check_state();
        check("point", point, 8'(m_point));
        check("turn_b", turn_b, 8'(m_turn));
        check("score_a", score_a, 8'(m_score[0]));
        check("score_b", score_b, 8'(m_score[1]));
        check("match_over", match_over, 8'(m_over));
        check("winner_b", winner_b, 8'((m_over != 0) ? m_winner : 0));
        check("inc_idle", inc, 8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; roll_a = 1'b0; roll_b = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_state();
        check("round_win_rst", round_win, 8'd0);
        check("round_lose_rst", round_lose, 8'd0);
    endtask

    // Owner holds its button for h rising edges; non-owner button chatters meanwhile.
    task automatic do_roll(input int h, input int s);
        int owner, over;
        owner = m_turn;
        over  = m_over;
        model_roll(h, s);
        sum = 4'(s);
        @(posedge clk); #1;
        for (int i = 0; i < h; i++) begin
            if (over != 0) begin
                roll_a = 1'b1; roll_b = 1'b1;
            end else if (owner == 0) begin
                roll_a = 1'b1; roll_b = 1'($urandom_range(0, 1));
            end else begin
                roll_b = 1'b1; roll_a = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        roll_a = 1'b0; roll_b = 1'b0;
        repeat (RESULT_CYC + 4) @(posedge clk);
        #1;
        check_state();
    endtask

    // Monitor: measures inc bursts and round-result holds, compares against queued items.
    int inc_run = 0;
    int res_run = 0;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            inc_q.delete();
            res_q.delete();
            inc_run = 0;
            res_run = 0;
        end else begin
            if (inc === 1'b1) inc_run++;
            else if (inc_run > 0) begin
                if (inc_q.size() == 0) check("inc_unexpected", 8'(inc_run), 8'd0);
                else check("inc_len", 8'(inc_run), 8'(inc_q.pop_front()));
                inc_run = 0;
            end
            if (round_win === 1'b1 || round_lose === 1'b1) begin
                if (res_run == 0) begin
                    if (res_q.size() == 0) check("res_unexpected", 8'd1, 8'd0);
                    else begin
                        res_t e;
                        e = res_q.pop_front();
                        check("res_win", round_win, 8'(e.win));
                        check("res_lose", round_lose, 8'(!e.win));
                        check("res_score_a", score_a, 8'(e.sa));
                        check("res_score_b", score_b, 8'(e.sb));
                        check("res_turn", turn_b, 8'(e.turn));
                        check("res_point", point, 8'(e.pt));
                    end
                end
                res_run++;
            end else if (res_run > 0) begin
                check("res_hold", 8'(res_run), 8'(RESULT_CYC));
                res_run = 0;
            end
        end
    end

    initial begin
        int over_rolls;
        int h, s;
        rst = 1'b1; roll_a = 1'b0; roll_b = 1'b0; sum = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        do_roll(4, 7);    // A come-out win
        do_roll(3, 12);   // B craps out
        // B's button while A owns the dice is ignored
        roll_b = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        roll_b = 1'b0;
        check_state();
        do_roll(2, 6);    // A sets point 6
        do_roll(3, 9);
        do_roll(2, 6);    // A makes the point
        do_roll(2, 8);    // B sets point 8
        do_roll(2, 7);    // B sevens out
        do_roll(2, 0);    // invalid come-out, A keeps the turn
        do_roll(2, 11);   // A reaches the target
        check("over_directed", match_over, 8'd1);
        do_roll(3, 7);    // ignored in MATCH_END
        do_reset();

        // Reset in the middle of a point roll
        do_roll(2, 5);
        sum = 4'd5;
        @(posedge clk); #1;
        roll_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("inc_mid_roll", inc, 8'd1);
        do_reset();

        over_rolls = 0;
        for (int n = 0; n < 250; n++) begin
            if (m_over != 0) begin
                over_rolls++;
                if (over_rolls > 2) begin
                    do_reset();
                    over_rolls = 0;
                    continue;
                end
            end
            h = $urandom_range(2, 6);
            if (m_point != 0 && $urandom_range(0, 3) == 0) s = m_point;
            else if ($urandom_range(0, 9) == 0) s = $urandom_range(0, 1) ? $urandom_range(13, 15)
                                                                       : $urandom_range(0, 1);
            else s = $urandom_range(2, 12);
            do_roll(h, s);
        end

        check("inc_q_drained", 8'(inc_q.size()), 8'd0);
        check("res_q_drained", 8'(res_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
